// File: rtl/axi4_slave_mem.sv
// AXI4 burst responder backed by an internal byte-enabled memory, with independent write and read FSMs.
// Define AXI4_SLAVE_WRAP_EN to support WRAP bursts; otherwise WRAP is answered with SLVERR.
module axi4_slave_mem #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_MEM_DEPTH        = 64
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    localparam int AW        = C_S_AXI_ADDR_WIDTH;
    localparam int BYTES     = C_S_AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB  = $clog2(BYTES);
    localparam int IDX_W     = $clog2(C_MEM_DEPTH);
    localparam int MEM_BYTES = C_MEM_DEPTH * BYTES;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI4_SLAVE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
        logic err;
        err = (size != 3'(ADDR_LSB)) || (burst == 2'b11);
        if (burst == 2'b10)
            err = err || !WRAP_EN || !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return err;
    endfunction

    // INCR deliberately runs off the end of memory instead of wrapping, so later beats stay out of range.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [1:0] burst,
                                                input logic [7:0] len);
        logic [AW-1:0] inc;
        logic [AW-1:0] mask;
        inc  = addr + AW'(BYTES);
        mask = ((AW'(len) + AW'(1)) << ADDR_LSB) - AW'(1);
        case (burst)
            2'b00:   return addr;
            2'b10:   return WRAP_EN ? ((addr & ~mask) | (inc & mask)) : inc;
            default: return inc;
        endcase
    endfunction

    function automatic logic in_range(input logic [AW-1:0] addr);
        return addr < AW'(MEM_BYTES);
    endfunction

    logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [C_MEM_DEPTH];

    // ---------------- write channel ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    w_state_t r_w_state, w_w_state_next;

    logic                        r_awready, r_wready, r_bvalid, r_w_err, r_w_drop;
    logic [1:0]                  r_bresp, r_awburst;
    logic [7:0]                  r_awlen, r_w_cnt;
    logic [AW-1:0]               r_awaddr;
    logic [C_S_AXI_ID_WIDTH-1:0] r_bid;

    logic w_aw_hs, w_w_hs, w_b_hs, w_w_last_beat, w_w_beat_err, w_mem_we;
    logic [IDX_W-1:0] w_w_idx;

    assign w_aw_hs       = S_AXI_AWVALID && r_awready;
    assign w_w_hs        = S_AXI_WVALID && r_wready;
    assign w_b_hs        = S_AXI_BREADY && r_bvalid;
    assign w_w_last_beat = (r_w_cnt == r_awlen);
    assign w_w_beat_err  = !in_range(r_awaddr) || (S_AXI_WLAST != w_w_last_beat);
    assign w_mem_we      = w_w_hs && in_range(r_awaddr) && !r_w_drop;
    assign w_w_idx       = r_awaddr[ADDR_LSB +: IDX_W];

    always_comb begin
        w_w_state_next = r_w_state;
        case (r_w_state)
            W_IDLE:  if (w_aw_hs) w_w_state_next = W_DATA;
            W_DATA:  if (w_w_hs && w_w_last_beat) w_w_state_next = W_RESP;
            W_RESP:  if (w_b_hs) w_w_state_next = W_IDLE;
            default: w_w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_w_state <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_bid     <= '0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awburst <= '0;
            r_w_cnt   <= '0;
            r_w_err   <= 1'b0;
            r_w_drop  <= 1'b0;
        end else begin
            r_w_state <= w_w_state_next;
            r_awready <= (w_w_state_next == W_IDLE);
            r_wready  <= (w_w_state_next == W_DATA);
            r_bvalid  <= (w_w_state_next == W_RESP);
            if (w_aw_hs) begin
                r_bid     <= S_AXI_AWID;
                r_awaddr  <= S_AXI_AWADDR;
                r_awlen   <= S_AXI_AWLEN;
                r_awburst <= S_AXI_AWBURST;
                r_w_cnt   <= '0;
                r_w_drop  <= burst_err(S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLEN);
                r_w_err   <= burst_err(S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLEN);
            end
            if (w_w_hs) begin
                r_w_cnt  <= r_w_cnt + 8'd1;
                r_awaddr <= next_addr(r_awaddr, r_awburst, r_awlen);
                if (w_w_beat_err) r_w_err <= 1'b1;
                if (w_w_last_beat) r_bresp <= (r_w_err || w_w_beat_err) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_mem_we) begin
            for (int b = 0; b < BYTES; b++)
                if (S_AXI_WSTRB[b]) r_mem[w_w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
    end

    // ---------------- read channel ----------------
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    r_state_t r_r_state, w_r_state_next;

    logic                          r_arready, r_rvalid, r_rlast, r_r_drop;
    logic [1:0]                    r_rresp, r_arburst;
    logic [7:0]                    r_arlen, r_r_cnt;
    logic [AW-1:0]                 r_araddr;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_rid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    logic             w_ar_hs, w_r_hs, w_rd_load, w_rd_err, w_rd_ok, w_r_idle;
    logic [AW-1:0]    w_rd_addr;
    logic [1:0]       w_rd_burst;
    logic [7:0]       w_rd_len;
    logic [IDX_W-1:0] w_rd_idx;

    // In IDLE the first beat is fetched straight from the AR channel so RVALID can follow one cycle later.
    assign w_r_idle   = (r_r_state == R_IDLE);
    assign w_ar_hs    = S_AXI_ARVALID && r_arready;
    assign w_r_hs     = r_rvalid && S_AXI_RREADY;
    assign w_rd_load  = w_ar_hs || (w_r_hs && !r_rlast);
    assign w_rd_addr  = w_r_idle ? S_AXI_ARADDR  : r_araddr;
    assign w_rd_burst = w_r_idle ? S_AXI_ARBURST : r_arburst;
    assign w_rd_len   = w_r_idle ? S_AXI_ARLEN   : r_arlen;
    assign w_rd_err   = w_r_idle ? burst_err(S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLEN) : r_r_drop;
    assign w_rd_ok    = !w_rd_err && in_range(w_rd_addr);
    assign w_rd_idx   = w_rd_addr[ADDR_LSB +: IDX_W];

    always_comb begin
        w_r_state_next = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_hs) w_r_state_next = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast) w_r_state_next = R_IDLE;
            default: w_r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_r_state <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rid     <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arburst <= '0;
            r_r_cnt   <= '0;
            r_r_drop  <= 1'b0;
        end else begin
            r_r_state <= w_r_state_next;
            r_arready <= (w_r_state_next == R_IDLE);
            r_rvalid  <= (w_r_state_next == R_DATA);
            if (w_ar_hs) begin
                r_rid     <= S_AXI_ARID;
                r_arlen   <= S_AXI_ARLEN;
                r_arburst <= S_AXI_ARBURST;
                r_r_drop  <= w_rd_err;
                r_r_cnt   <= '0;
                r_rlast   <= (S_AXI_ARLEN == 8'd0);
            end else if (w_rd_load) begin
                r_r_cnt <= r_r_cnt + 8'd1;
                r_rlast <= ((r_r_cnt + 8'd1) == r_arlen);
            end else if (w_r_hs) begin
                r_rlast <= 1'b0;
            end
            if (w_rd_load) begin
                r_rdata  <= w_rd_ok ? r_mem[w_rd_idx] : '0;
                r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                r_araddr <= next_addr(w_rd_addr, w_rd_burst, w_rd_len);
            end
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_BID     = r_bid;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RLAST   = r_rlast;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RID     = r_rid;
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: bursts, strobes, range/size/WLAST errors, RREADY stalls, WRAP, reset.
module tb_axi4_slave_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awid = 1'b0, arid = 1'b0;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid, rlast, bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int checks = 0, failures = 0;
    logic [31:0] wr_data [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    int          rd_beats, lat_w, lat_b, stable_viol;
    logic [1:0]  b_resp;
    logic        b_id, r_id, first_rvalid;

    always #5 clk = ~clk;

    axi4_slave_mem dut (
        .ACLK(clk), .ARESETN(rst_n),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
        .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    task automatic timeout_fail(input string what);
        checks++;
        failures++;
        $display("FAIL timeout_%s: handshake never completed, required within 50 cycles", what);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] strb, input int last_idx,
                            input logic id);
        int t;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) timeout_fail("aw");
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wr_data[i]; wstrb = strb; wlast = (i == last_idx); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) timeout_fail("w");
            if (i == 0) lat_w = t;
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) timeout_fail("b");
        lat_b = t; b_resp = bresp; b_id = bid;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic id, input bit toggle);
        int t, cyc;
        logic hold_valid;
        logic [31:0] hold_data;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) timeout_fail("ar");
        @(negedge clk);
        arvalid = 1'b0;
        first_rvalid = rvalid;
        rd_beats = 0; cyc = 0; hold_valid = 1'b0; hold_data = '0; stable_viol = 0;
        while (rd_beats <= int'(len) && cyc < 200) begin
            rready = toggle ? cyc[0] : 1'b1;
            if (hold_valid && (!rvalid || rdata !== hold_data)) stable_viol++;
            if (rvalid) begin
                if (rready) begin
                    rd_data[rd_beats] = rdata; rd_resp[rd_beats] = rresp;
                    rd_last[rd_beats] = rlast; r_id = rid;
                    rd_beats++;
                    hold_valid = 1'b0;
                end else begin
                    hold_valid = 1'b1; hold_data = rdata;
                end
            end
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        if (cyc >= 200) timeout_fail("r");
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, bresp, bid, arready, rvalid, rlast, rdata, rresp, rid} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got aw=%b w=%b b=%b ar=%b r=%b rdata=%h, required all zero",
                     awready, wready, bvalid, arready, rvalid, rdata);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({awready, arready} !== 2'b00) begin
            failures++; $display("FAIL ready_before_edge: got %b%b, required 00", awready, arready);
        end
        @(negedge clk);
        checks++;
        if ({awready, arready} !== 2'b11) begin
            failures++; $display("FAIL ready_after_reset: got %b%b, required 11", awready, arready);
        end
    endtask

    task automatic test_incr;
        for (int i = 0; i < 16; i++) wr_data[i] = 32'(i + 1);
        do_write(32'h0, 8'd15, 2'b01, 3'd2, 4'hF, 15, 1'b1);
        checks++;
        if ({b_resp, b_id, lat_w, lat_b} !== {2'b00, 1'b1, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL incr_write: bresp=%b bid=%b wlat=%0d blat=%0d, required 00 1 0 0", b_resp, b_id, lat_w, lat_b);
        end
        do_read(32'h0, 8'd15, 2'b01, 3'd2, 1'b1, 1'b0);
        checks++;
        if ({first_rvalid, r_id} !== 2'b11 || rd_beats != 16) begin
            failures++;
            $display("FAIL incr_read_hdr: rvalid=%b rid=%b beats=%0d, required 1 1 16", first_rvalid, r_id, rd_beats);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({rd_data[i], rd_resp[i], rd_last[i]} !== {32'(i + 1), 2'b00, (i == 15)}) begin
                failures++;
                $display("FAIL incr_beat%0d: got data=%h resp=%b last=%b, required data=%h resp=00 last=%b",
                         i, rd_data[i], rd_resp[i], rd_last[i], 32'(i + 1), (i == 15));
            end
        end
        checks++;
        if (rvalid !== 1'b0) begin failures++; $display("FAIL incr_rvalid_drop: got %b, required 0", rvalid); end
    endtask

    task automatic test_fixed;
        wr_data[0] = 32'hA; wr_data[1] = 32'hB; wr_data[2] = 32'hC; wr_data[3] = 32'hD;
        do_write(32'h10, 8'd3, 2'b00, 3'd2, 4'hF, 3, 1'b0);
        checks++;
        if (b_resp !== 2'b00) begin failures++; $display("FAIL fixed_bresp: got %b, required 00", b_resp); end
        do_read(32'h10, 8'd0, 2'b01, 3'd2, 1'b0, 1'b0);
        checks++;
        if ({rd_data[0], rd_resp[0], rd_last[0]} !== {32'hD, 2'b00, 1'b1}) begin
            failures++; $display("FAIL fixed_read: got %h/%b/%b, required 0000000d/00/1", rd_data[0], rd_resp[0], rd_last[0]);
        end
        do_read(32'h14, 8'd0, 2'b01, 3'd2, 1'b0, 1'b0);
        checks++;
        if (rd_data[0] !== 32'h6) begin failures++; $display("FAIL fixed_neighbour: got %h, required 00000006", rd_data[0]); end
    endtask

    task automatic test_strobe;
        wr_data[0] = 32'h12345678;
        do_write(32'h20, 8'd0, 2'b01, 3'd2, 4'hF, 0, 1'b0);
        wr_data[0] = 32'hFFFFFFFF;
        do_write(32'h20, 8'd0, 2'b01, 3'd2, 4'b0101, 0, 1'b0);
        do_read(32'h20, 8'd0, 2'b01, 3'd2, 1'b0, 1'b0);
        checks++;
        if (rd_data[0] !== 32'h12FF56FF) begin failures++; $display("FAIL strobe: got %h, required 12ff56ff", rd_data[0]); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] exp_d [4];
        logic [1:0]  exp_r [4];
        exp_d = '{32'h55, 32'h66, 32'h0, 32'h0};
        exp_r = '{2'b00, 2'b00, 2'b10, 2'b10};
        wr_data[0] = 32'h55; wr_data[1] = 32'h66;
        do_write(32'hF8, 8'd1, 2'b01, 3'd2, 4'hF, 1, 1'b0);
        checks++;
        if (b_resp !== 2'b00) begin failures++; $display("FAIL oor_inrange_bresp: got %b, required 00", b_resp); end
        do_read(32'hF8, 8'd3, 2'b01, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rd_data[i], rd_resp[i]} !== {exp_d[i], exp_r[i]}) begin
                failures++;
                $display("FAIL oor_beat%0d: got %h/%b, required %h/%b", i, rd_data[i], rd_resp[i], exp_d[i], exp_r[i]);
            end
        end
        wr_data[0] = 32'h77; wr_data[1] = 32'h88;
        do_write(32'hFC, 8'd1, 2'b01, 3'd2, 4'hF, 1, 1'b0);
        checks++;
        if (b_resp !== 2'b10) begin failures++; $display("FAIL oor_write_bresp: got %b, required 10", b_resp); end
        do_read(32'hFC, 8'd0, 2'b01, 3'd2, 1'b0, 1'b0);
        checks++;
        if ({rd_data[0], rd_resp[0]} !== {32'h77, 2'b00}) begin
            failures++; $display("FAIL oor_partial_write: got %h/%b, required 00000077/00", rd_data[0], rd_resp[0]);
        end
    endtask

    task automatic test_wlast_err;
        for (int i = 0; i < 4; i++) wr_data[i] = 32'h100 + 32'(i);
        do_write(32'h40, 8'd3, 2'b01, 3'd2, 4'hF, 2, 1'b0);
        checks++;
        if (b_resp !== 2'b10) begin failures++; $display("FAIL wlast_early: got %b, required 10", b_resp); end
        do_write(32'h40, 8'd0, 2'b01, 3'd2, 4'hF, 0, 1'b0);
        checks++;
        if (b_resp !== 2'b00) begin failures++; $display("FAIL wlast_flag_cleared: got %b, required 00", b_resp); end
    endtask

    task automatic test_size_err;
        wr_data[0] = 32'hDEAD;
        do_write(32'h20, 8'd0, 2'b01, 3'd1, 4'hF, 0, 1'b0);
        checks++;
        if (b_resp !== 2'b10) begin failures++; $display("FAIL size_bresp: got %b, required 10", b_resp); end
        do_read(32'h20, 8'd0, 2'b01, 3'd2, 1'b0, 1'b0);
        checks++;
        if (rd_data[0] !== 32'h12FF56FF) begin failures++; $display("FAIL size_write_dropped: got %h, required 12ff56ff", rd_data[0]); end
        do_read(32'h20, 8'd1, 2'b01, 3'd1, 1'b0, 1'b0);
        checks++;
        if ({rd_resp[0], rd_resp[1], rd_last[1]} !== 5'b10101) begin
            failures++; $display("FAIL size_read_resp: got %b %b last=%b, required 10 10 1", rd_resp[0], rd_resp[1], rd_last[1]);
        end
    endtask

    task automatic test_rready_toggle;
        logic [31:0] exp_d;
        do_read(32'h0, 8'd7, 2'b01, 3'd2, 1'b0, 1'b1);
        checks++;
        if (stable_viol != 0 || rd_beats != 8) begin
            failures++; $display("FAIL toggle_stable: violations=%0d beats=%0d, required 0 8", stable_viol, rd_beats);
        end
        for (int i = 0; i < 8; i++) begin
            exp_d = (i == 4) ? 32'hD : 32'(i + 1);
            checks++;
            if ({rd_data[i], rd_last[i]} !== {exp_d, (i == 7)}) begin
                failures++;
                $display("FAIL toggle_beat%0d: got %h/%b, required %h/%b", i, rd_data[i], rd_last[i], exp_d, (i == 7));
            end
        end
    endtask

    task automatic test_wrap;
        do_read(32'h08, 8'd3, 2'b10, 3'd2, 1'b0, 1'b0);
`ifdef AXI4_SLAVE_WRAP_EN
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rd_data[i], rd_resp[i]} !== {32'((i + 2) % 4 + 1), 2'b00}) begin
                failures++;
                $display("FAIL wrap_beat%0d: got %h/%b, required %h/00", i, rd_data[i], rd_resp[i], 32'((i + 2) % 4 + 1));
            end
        end
        wr_data[0] = 32'h99; wr_data[1] = 32'h9A;
        do_write(32'h0C, 8'd1, 2'b10, 3'd2, 4'hF, 1, 1'b0);
        do_read(32'h08, 8'd1, 2'b01, 3'd2, 1'b0, 1'b0);
        checks++;
        if ({b_resp, rd_data[0], rd_data[1]} !== {2'b00, 32'h9A, 32'h99}) begin
            failures++; $display("FAIL wrap_write: got %b %h %h, required 00 0000009a 00000099", b_resp, rd_data[0], rd_data[1]);
        end
`else
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rd_resp[i], rd_last[i]} !== {2'b10, (i == 3)}) begin
                failures++;
                $display("FAIL nowrap_beat%0d: got %b/%b, required 10/%b", i, rd_resp[i], rd_last[i], (i == 3));
            end
        end
        wr_data[0] = 32'h99; wr_data[1] = 32'h9A;
        do_write(32'h08, 8'd1, 2'b10, 3'd2, 4'hF, 1, 1'b0);
        do_read(32'h08, 8'd0, 2'b01, 3'd2, 1'b0, 1'b0);
        checks++;
        if ({b_resp, rd_data[0]} !== {2'b10, 32'h3}) begin
            failures++; $display("FAIL nowrap_write: got %b %h, required 10 00000003", b_resp, rd_data[0]);
        end
`endif
    endtask

    task automatic test_back_to_back;
        wr_data[0] = 32'hCAFE0001; wr_data[1] = 32'hCAFE0002;
        do_write(32'h60, 8'd0, 2'b01, 3'd2, 4'hF, 0, 1'b0);
        checks++;
        if (awready !== 1'b1) begin failures++; $display("FAIL b2b_awready: got %b, required 1", awready); end
        wr_data[0] = 32'hCAFE0002;
        do_write(32'h64, 8'd0, 2'b01, 3'd2, 4'hF, 0, 1'b1);
        do_read(32'h60, 8'd1, 2'b01, 3'd2, 1'b0, 1'b0);
        checks++;
        if ({b_resp, b_id, rd_data[0], rd_data[1]} !== {2'b00, 1'b1, 32'hCAFE0001, 32'hCAFE0002}) begin
            failures++;
            $display("FAIL b2b_data: got %b %b %h %h, required 00 1 cafe0001 cafe0002", b_resp, b_id, rd_data[0], rd_data[1]);
        end
    endtask

    task automatic test_reset_midburst;
        int t;
        @(negedge clk);
        arid = 1'b0; araddr = 32'h0; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) timeout_fail("mid_ar");
        @(negedge clk);
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1) begin failures++; $display("FAIL mid_rvalid: got %b, required 1", rvalid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rvalid, arready, awready, rdata} !== '0) begin
            failures++; $display("FAIL mid_async_reset: rvalid=%b arready=%b rdata=%h, required 0 0 0", rvalid, arready, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(32'h4, 8'd0, 2'b01, 3'd2, 1'b0, 1'b0);
        checks++;
        if ({rd_data[0], rd_resp[0]} !== {32'h2, 2'b00}) begin
            failures++; $display("FAIL mid_mem_kept: got %h/%b, required 00000002/00", rd_data[0], rd_resp[0]);
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_fixed();
        test_strobe();
        test_out_of_range();
        test_wlast_err();
        test_size_err();
        test_rready_toggle();
        test_wrap();
        test_back_to_back();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
